four_product_sum_sequencer: RTL and testbench
=============================================

# four_product_sum_sequencer

Time-multiplexed controller that computes the sum of four unsigned products a0*b0 + a1*b1 + a2*b2 + a3*b3 using one shared registered multiplier and one accumulator. It is the sequencing counterpart to the parallel four-multiplier adder in the negative-edge DSP test set. It accepts operand pairs over a valid/ready handshake, schedules them through the multiplier, and presents the 4-term sum on an output valid/ready handshake. All state updates occur on the falling edge of the clock.

## Interface
- INPUT_WIDTH, 14, width of each operand a and b.
- OUTPUT_WIDTH, 30, width of y. Must equal 2*INPUT_WIDTH+2 so the 4-term sum never overflows.
- clk  input  1  clock; every flop updates on the falling edge.
- reset  input  1  synchronous, active-low reset, sampled on the falling edge of clk.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept a pair.
- a  input  INPUT_WIDTH  unsigned operand; index 0 is the MSB ([0:INPUT_WIDTH-1]).
- b  input  INPUT_WIDTH  unsigned operand; index 0 is the MSB.
- out_valid  output  1  y holds a completed sum.
- out_ready  input  1  consumer accepts y.
- y  output  OUTPUT_WIDTH  registered sum of four products; index 0 is the MSB.
- pair_cnt  output  2  number of pairs accepted in the current sequence, 0..3.

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- Reset (reset==0 at a falling edge) forces:
  - state=IDLE
  - in_ready=1, out_valid=0, y=0, pair_cnt=0
  - internal product p=0, p_vld=0, acc=0
  - Reset takes priority over every other event, including mid-sequence and during DONE.
- Accept condition: in_valid & in_ready at a falling edge. The accepting edge registers p<=a*b (unsigned, 2*INPUT_WIDTH bits) and sets p_vld<=1. If no pair is accepted, p_vld<=0.
- Accumulate: on each edge where p_vld==1, acc<=acc+p, zero-extended to OUTPUT_WIDTH.
- IDLE:
  - in_ready=1 and acc=0.
  - An accepted pair moves the state to COLLECT with pair_cnt<=1.
- COLLECT:
  - in_ready=1.
  - Each accepted pair increments pair_cnt.
  - The accept with pair_cnt==3 (the 4th pair) moves to DRAIN and wraps pair_cnt to 0.
  - Gaps on in_valid are allowed and do not affect the result.
- DRAIN:
  - in_ready=0.
  - On the next edge the last product is added, y<=acc+p, out_valid<=1, and the state moves to DONE.
- DONE:
  - in_ready=0; y and out_valid hold stable.
  - On an edge with out_ready==1: out_valid<=0, acc<=0, state IDLE. y keeps its last value.
- in_ready is decoded combinationally from state (IDLE or COLLECT). It never depends on in_valid.

## Timing
- Throughput: one pair accepted per clock edge while in_ready=1.
- Latency: out_valid rises on the 1st falling edge after the edge that accepted the 4th pair.
- Minimum sequence: 4 accept edges, 1 DRAIN edge, then out_valid=1. With out_ready held at 1, out_valid drops 1 edge later.
- A new pair can be accepted on the edge after DONE exits (IDLE). The minimum period per result is 6 edges.
- out_ready is ignored outside DONE. in_valid is ignored in DRAIN and DONE, and no pair is consumed.
- Maximum value: 4*(2^INPUT_WIDTH-1)^2 < 2^OUTPUT_WIDTH, so there is no overflow or wrap for legal parameters.
- Inputs are driven by the bench away from the falling edge; sampling happens on the falling edge only.

## Test plan
- Reset check:
  - Hold reset=0 for 2 edges with in_valid=1, a=5, b=5.
  - Expect y=0, out_valid=0, pair_cnt=0, in_ready=1.
- Basic sum:
  - Pairs (0,1), (5,10), (1,1), (2,2) back-to-back, out_ready=1.
  - Expect y=55 with out_valid=1 exactly 1 edge after the 4th accept, then out_valid=0 on the next edge.
- Maximum operands:
  - Four pairs (14'h3fff, 14'h3fff).
  - Expect y=1073610756 with no overflow.
- Gaps and back-pressure:
  - Pairs (3,1), (4,6), (1,1), (2,2) with 2 idle cycles between each; out_ready=0 for 5 edges after out_valid.
  - Expect y=32 held stable with in_ready=0 throughout.
  - Raise out_ready: state returns to IDLE and the next pair is accepted on the following edge.
- Reset mid-operation:
  - After 2 accepted pairs, assert reset=0 for 1 edge.
  - Expect all outputs at reset values.
  - A fresh sequence (1,1), (1,1), (1,1), (1,1) gives y=4, with no residue from the aborted pairs.
- Back-to-back sequences:
  - Two consecutive 4-pair bursts (2,3)x4 and (1,2)x4, out_ready=1.
  - Expect y=24, then y=8.
  - Pairs offered during DRAIN or DONE are not consumed (in_ready=0).

Source files
------------

// File: rtl/four_product_sum_sequencer.sv
// four_product_sum_sequencer
// Computes a0*b0 + a1*b1 + a2*b2 + a3*b3 with one shared registered multiplier
// and one accumulator. Operand pairs arrive over a valid/ready handshake. The
// sum leaves over a valid/ready handshake. Every flop updates on the falling
// edge of i_clk. Operand and result buses are MSB-first ([0:W-1]).
module four_product_sum_sequencer #(
   parameter int INPUT_WIDTH  = 14,
   parameter int OUTPUT_WIDTH = 30
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [0:INPUT_WIDTH-1]  i_a,
   input  logic [0:INPUT_WIDTH-1]  i_b,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [0:OUTPUT_WIDTH-1] o_y,
   output logic [1:0]              o_pair_cnt
);

   localparam int PW = 2 * INPUT_WIDTH;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]              r_state;
   logic [PW-1:0]           r_p;
   logic                    r_p_vld;
   logic [OUTPUT_WIDTH-1:0] r_acc;
   logic [OUTPUT_WIDTH-1:0] r_y;
   logic                    r_out_valid;
   logic [1:0]              r_pair_cnt;

   logic                    w_accept;
   logic [PW-1:0]           w_prod;
   logic [OUTPUT_WIDTH-1:0] w_sum;

   // Both handshake sides are decoded from state alone, so in_ready never
   // depends on in_valid.
   assign o_in_ready = (r_state == S_IDLE) || (r_state == S_COLLECT);
   assign w_accept   = i_in_valid & o_in_ready;

   // Operands are widened first so the multiply is evaluated at full width.
   assign w_prod = {{INPUT_WIDTH{1'b0}}, i_a} * {{INPUT_WIDTH{1'b0}}, i_b};
   assign w_sum  = r_acc + OUTPUT_WIDTH'(r_p);

   assign o_y         = r_y;
   assign o_out_valid = r_out_valid;
   assign o_pair_cnt  = r_pair_cnt;

   // Multiplier stage: register the product of each accepted pair. p_vld
   // marks that p still has to be folded into the accumulator.
   always_ff @(negedge i_clk) begin
      if (!i_reset) begin
         r_p     <= '0;
         r_p_vld <= 1'b0;
      end else if (w_accept) begin
         r_p     <= w_prod;
         r_p_vld <= 1'b1;
      end else begin
         r_p_vld <= 1'b0;
      end
   end

   // Accumulator: fold in each pending product. It is cleared when a result
   // is handed off, so the next sequence starts from zero.
   always_ff @(negedge i_clk) begin
      if (!i_reset) begin
         r_acc <= '0;
      end else if (r_state == S_DONE && i_out_ready) begin
         r_acc <= '0;
      end else if (r_p_vld) begin
         r_acc <= w_sum;
      end
   end

   // Sequencer: count four accepts, spend one edge draining the last product
   // into y, then hold the result until the consumer takes it.
   always_ff @(negedge i_clk) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_pair_cnt  <= 2'd0;
         r_y         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state    <= S_COLLECT;
                  r_pair_cnt <= 2'd1;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  // The 4th accept wraps the count back to 0.
                  r_pair_cnt <= r_pair_cnt + 2'd1;
                  if (r_pair_cnt == 2'd3) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_y         <= w_sum;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            default: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_four_product_sum_sequencer.sv
// Directed bench for four_product_sum_sequencer. Inputs change 2 time units
// after each falling edge, and outputs are checked at the same point, so they
// are never sampled on the active edge.
module tb_four_product_sum_sequencer;

   logic        clk = 1'b1;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [0:13] a;
   logic [0:13] b;
   logic        out_valid;
   logic        out_ready;
   logic [0:29] y;
   logic [1:0]  pair_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   four_product_sum_sequencer #(.INPUT_WIDTH(14), .OUTPUT_WIDTH(30)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_a        (a),
      .i_b        (b),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_y        (y),
      .o_pair_cnt (pair_cnt)
   );

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer one pair for exactly one falling edge.
   task automatic send(input int av, input int bv);
      in_valid = 1'b1;
      a = 14'(av);
      b = 14'(bv);
      tick();
   endtask

   task automatic chk_all(input string tag, input int ey, input int eov,
                          input int ecnt, input int erdy);
      chk({tag, ".y"},         32'(y),         32'(ey));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
      chk({tag, ".pair_cnt"},  32'(pair_cnt),  32'(ecnt));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(erdy));
   endtask

   initial begin
      // Reset with a pair offered: nothing may be accepted.
      reset = 1'b0; in_valid = 1'b1; a = 14'd5; b = 14'd5; out_ready = 1'b0;
      #2;
      tick(); tick();
      chk_all("reset", 0, 0, 0, 1);
      reset = 1'b1;

      // Basic sum: 0*1 + 5*10 + 1*1 + 2*2 = 55.
      out_ready = 1'b1;
      send(0, 1); send(5, 10); send(1, 1);
      chk("basic.cnt3", 32'(pair_cnt), 32'd3);
      send(2, 2);
      in_valid = 1'b0;
      chk_all("basic.drain", 0, 0, 0, 0);
      tick();
      chk_all("basic.done", 55, 1, 0, 0);
      tick();
      chk_all("basic.idle", 55, 0, 0, 1);

      // Maximum operands: 4 * 16383^2 = 1073610756.
      for (int i = 0; i < 4; i++) send(16383, 16383);
      in_valid = 1'b0;
      tick();
      chk_all("max.done", 1073610756, 1, 0, 0);
      tick();
      chk("max.ov_drop", 32'(out_valid), 32'd0);

      // Gaps and back-pressure: 3 + 24 + 1 + 4 = 32.
      out_ready = 1'b0;
      send(3, 1); in_valid = 1'b0; tick(); tick();
      send(4, 6); in_valid = 1'b0; tick(); tick();
      chk("gap.cnt2", 32'(pair_cnt), 32'd2);
      send(1, 1); in_valid = 1'b0; tick(); tick();
      send(2, 2);
      // Offered during DRAIN/DONE; must not be consumed.
      in_valid = 1'b1; a = 14'd7; b = 14'd7;
      tick();
      chk_all("gap.done", 32, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_all("gap.hold", 32, 1, 0, 0);
      end
      out_ready = 1'b1;
      tick();
      chk_all("gap.release", 32, 0, 0, 1);
      // The (7,7) pair still offered is accepted on the very next edge.
      out_ready = 1'b0;
      tick();
      chk("gap.next_accept", 32'(pair_cnt), 32'd1);

      // Reset mid-operation after 2 accepted pairs.
      send(7, 7);
      chk("mid.cnt2", 32'(pair_cnt), 32'd2);
      reset = 1'b0; in_valid = 1'b0;
      tick();
      chk_all("mid.reset", 0, 0, 0, 1);
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(1, 1);
      in_valid = 1'b0;
      tick();
      chk_all("mid.fresh", 4, 1, 0, 0);
      tick();

      // Back-to-back bursts: (2,3)x4 = 24, then (1,2)x4 = 8.
      for (int i = 0; i < 4; i++) send(2, 3);
      in_valid = 1'b1; a = 14'd9; b = 14'd9;
      tick();
      chk_all("b2b.first", 24, 1, 0, 0);
      tick();
      chk_all("b2b.exit", 24, 0, 0, 1);
      for (int i = 0; i < 4; i++) send(1, 2);
      in_valid = 1'b0;
      tick();
      chk_all("b2b.second", 8, 1, 0, 0);
      tick();
      chk("b2b.ov_drop", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
